// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: decoder op encoding,
// scheduler states, default latencies and the HI/LO result pair.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam logic [2:0] MD_MFLO  = 3'b110;
  localparam logic [2:0] MD_MFHI  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_pair_t;

  // Ops 0xx occupy the unit; 1xx are register moves/reads.
  function automatic logic is_busy_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// res_valid is low when HI/LO must be left untouched (divide by zero, non-arith op).
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        res_valid
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  logic               b_zero;
  logic               s_ovf;
  logic        [31:0] b_s;
  logic        [31:0] b_u;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic        [31:0] u_quo;
  logic        [31:0] u_rem;

  assign a_ext  = {{32{a[31]}}, a};
  assign b_ext  = {{32{b[31]}}, b};
  assign s_prod = a_ext * b_ext;
  assign u_prod = {32'd0, a} * {32'd0, b};

  // Dividing by 1 on overflow yields exactly the required LO=0x80000000, HI=0.
  assign b_zero = (b == 32'd0);
  assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_s    = (b_zero || s_ovf) ? 32'd1 : b;
  assign b_u    = b_zero ? 32'd1 : b;
  assign s_quo  = $signed(a) / $signed(b_s);
  assign s_rem  = $signed(a) % $signed(b_s);
  assign u_quo  = a / b_u;
  assign u_rem  = a % b_u;

  always_comb begin
    hi_res    = 32'd0;
    lo_res    = 32'd0;
    res_valid = 1'b0;
    case (op)
      MD_MULT: begin
        {hi_res, lo_res} = s_prod;
        res_valid        = 1'b1;
      end
      MD_MULTU: begin
        {hi_res, lo_res} = u_prod;
        res_valid        = 1'b1;
      end
      MD_DIV: begin
        lo_res    = s_quo;
        hi_res    = s_rem;
        res_valid = ~b_zero;
      end
      MD_DIVU: begin
        lo_res    = u_quo;
        hi_res    = u_rem;
        res_valid = ~b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// E-stage multiply/divide scheduler: fixed-latency busy window, HI/LO
// registers, move/read ops and the D-stage stall for MDU instructions.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  md_pair_t         pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic             busy_q, busy_d;

  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             res_valid;

  mdu_compute u_compute (
    .op        (mdu_op),
    .a         (rs_val),
    .b         (rt_val),
    .hi_res    (hi_res),
    .lo_res    (lo_res),
    .res_valid (res_valid)
  );

  // Next-state: results are computed at start and parked until the window closes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (start && is_busy_op(mdu_op)) begin
          pend_d.hi = hi_res;
          pend_d.lo = lo_res;
          pend_wr_d = res_valid;
          if (mdu_op[1]) begin
            cnt_d   = CNT_W'(DIV_CYCLES);
            state_d = ST_DIV;
          end else begin
            cnt_d   = CNT_W'(MULT_CYCLES);
            state_d = ST_MUL;
          end
        end else if (!start && mdu_op == MD_MTHI) begin
          hi_d = rs_val;
        end else if (!start && mdu_op == MD_MTLO) begin
          lo_d = rs_val;
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      busy_q    <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = d_uses_md & (start | busy_q);

  // Reads see committed HI/LO only.
  always_comb begin
    md_out = 32'd0;
    if (mdu_op == MD_MFLO) md_out = lo_q;
    else if (mdu_op == MD_MFHI) md_out = hi_q;
  end

endmodule
